// File: rtl/mac_tx_framer.sv
// mac_tx_framer: byte-wide Ethernet MAC transmit framer feeding an RGMII DDR stage.
// Wraps each payload frame with preamble and SFD, zero-pads short frames, appends the
// IEEE 802.3 CRC-32 FCS, and enforces an inter-frame gap. A source underrun mid-frame
// aborts the frame with a tx_er cycle and the rest of the frame is dropped.
//
// Ports:
//   mac_tx_clk    - clock, all logic on its rising edge
//   mac_tx_rst_n  - synchronous active-low reset
//   s_data        - payload byte
//   s_valid       - s_data valid
//   s_sof / s_eof - first / last byte of a frame, qualified by s_valid
//   s_ready       - byte accepted this cycle (combinational from state)
//   tx_data       - registered byte to the DDR stage
//   tx_dv / tx_er - registered TX_CTL data-valid / error
//   tx_underrun   - registered one-cycle pulse on a frame abort
//   frame_cnt     - frames sent complete, wraps
module mac_tx_framer #(
  parameter int unsigned PREAMBLE_LEN  = 7,
  parameter int unsigned IFG_LEN       = 12,
  parameter int unsigned MIN_FRAME_LEN = 60,
  parameter bit          FCS_EN        = 1'b1
) (
  input  logic        mac_tx_clk,
  input  logic        mac_tx_rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dv,
  output logic        tx_er,
  output logic        tx_underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0]  PreLen  = 4'(PREAMBLE_LEN);
  localparam logic [7:0]  IfgLast = 8'(IFG_LEN - 1);
  localparam logic [16:0] MinLen  = 17'(MIN_FRAME_LEN);
  localparam logic [31:0] CrcPoly = 32'hEDB88320;

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StData, StPad, StFcs, StDrop, StIfg
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_dv_q, tx_dv_d;
  logic        tx_er_q, tx_er_d;
  logic        tx_underrun_q, tx_underrun_d;
  logic        s_ready_c;

  logic [16:0] byte_inc;
  logic [15:0] byte_cnt_sat;
  logic [31:0] crc_inv;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CrcPoly & {32{c[0] ^ d[i]}});
    end
    return c;
  endfunction

  // Unsaturated count including the byte in flight, used for the pad decision.
  assign byte_inc     = {1'b0, byte_cnt_q} + 17'd1;
  assign byte_cnt_sat = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign crc_inv      = ~crc_q;

  always_comb begin
    unique case (fcs_idx_q)
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge mac_tx_clk) begin
    if (!mac_tx_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid && s_sof) begin
          state_d = (PREAMBLE_LEN <= 1) ? StSfd : StPreamble;
        end
      end
      StPreamble: begin
        if (pre_cnt_q + 4'd1 == PreLen) state_d = StSfd;
      end
      StSfd: state_d = StData;
      StData: begin
        if (!s_valid) begin
          state_d = StDrop;
        end else if (s_eof) begin
          if (byte_inc < MinLen) state_d = StPad;
          else if (FCS_EN)       state_d = StFcs;
          else                   state_d = StIfg;
        end
      end
      StPad: begin
        if (byte_inc >= MinLen) state_d = FCS_EN ? StFcs : StIfg;
      end
      StFcs: begin
        if (fcs_idx_q == 2'd3) state_d = StIfg;
      end
      StDrop: begin
        if (s_valid && s_eof) state_d = StIfg;
      end
      StIfg: begin
        if (ifg_cnt_q >= IfgLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values. Outputs are registered, so what is computed here
  // appears on tx_* one cycle later.
  always_comb begin
    s_ready_c     = 1'b0;
    tx_data_d     = 8'h00;
    tx_dv_d       = 1'b0;
    tx_er_d       = 1'b0;
    tx_underrun_d = 1'b0;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    fcs_idx_d     = fcs_idx_q;
    crc_d         = crc_q;
    frame_cnt_d   = frame_cnt_q;
    // Counts tx_dv-low cycles; parked at zero while a frame is on the wire.
    ifg_cnt_d     = (ifg_cnt_q == 8'hFF) ? ifg_cnt_q : ifg_cnt_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        // Non-sof bytes are flushed; the sof byte stays pending until DATA.
        s_ready_c = s_valid && !s_sof;
        if (s_valid && s_sof) begin
          // First preamble byte launches here so tx_dv rises the cycle after sof.
          tx_data_d = 8'h55;
          tx_dv_d   = 1'b1;
          pre_cnt_d = 4'd1;
        end
      end
      StPreamble: begin
        tx_data_d = 8'h55;
        tx_dv_d   = 1'b1;
        pre_cnt_d = pre_cnt_q + 4'd1;
        ifg_cnt_d = 8'd0;
      end
      StSfd: begin
        tx_data_d  = 8'hD5;
        tx_dv_d    = 1'b1;
        crc_d      = 32'hFFFF_FFFF;
        byte_cnt_d = 16'd0;
        fcs_idx_d  = 2'd0;
        ifg_cnt_d  = 8'd0;
      end
      StData: begin
        s_ready_c = 1'b1;
        ifg_cnt_d = 8'd0;
        tx_dv_d   = 1'b1;
        if (s_valid) begin
          tx_data_d  = s_data;
          crc_d      = crc32_byte(crc_q, s_data);
          byte_cnt_d = byte_cnt_sat;
          if (s_eof && !FCS_EN && !(byte_inc < MinLen)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          tx_er_d       = 1'b1;
          tx_underrun_d = 1'b1;
        end
      end
      StPad: begin
        tx_dv_d    = 1'b1;
        ifg_cnt_d  = 8'd0;
        crc_d      = crc32_byte(crc_q, 8'h00);
        byte_cnt_d = byte_cnt_sat;
        if (!FCS_EN && byte_inc >= MinLen) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      StFcs: begin
        tx_data_d = fcs_byte;
        tx_dv_d   = 1'b1;
        ifg_cnt_d = 8'd0;
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      StDrop: begin
        s_ready_c = 1'b1;
      end
      StIfg: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge mac_tx_clk) begin
    if (!mac_tx_rst_n) begin
      pre_cnt_q     <= 4'd0;
      byte_cnt_q    <= 16'd0;
      fcs_idx_q     <= 2'd0;
      ifg_cnt_q     <= 8'd0;
      crc_q         <= 32'd0;
      frame_cnt_q   <= 16'd0;
      tx_data_q     <= 8'h00;
      tx_dv_q       <= 1'b0;
      tx_er_q       <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      fcs_idx_q     <= fcs_idx_d;
      ifg_cnt_q     <= ifg_cnt_d;
      crc_q         <= crc_d;
      frame_cnt_q   <= frame_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_dv_q       <= tx_dv_d;
      tx_er_q       <= tx_er_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Held low in reset regardless of the state register's value.
  assign s_ready     = s_ready_c & mac_tx_rst_n;
  assign tx_data     = tx_data_q;
  assign tx_dv       = tx_dv_q;
  assign tx_er       = tx_er_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer. Two instances: A with default parameters, B with padding
// disabled. Stimulus pushes expected tx bytes into per-instance queues; a monitor pops and
// compares every tx_dv cycle and records tx_dv high/low run lengths for instance A.
module tb_mac_tx_framer;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
    logic       ur;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_sof, a_eof, a_ready;
  logic        b_valid, b_sof, b_eof, b_ready;
  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_dv, a_tx_er, a_tx_ur;
  logic        b_tx_dv, b_tx_er, b_tx_ur;
  logic [15:0] a_fcnt, b_fcnt;

  mac_tx_framer #(
    .PREAMBLE_LEN (7),
    .IFG_LEN      (12),
    .MIN_FRAME_LEN(60),
    .FCS_EN       (1'b1)
  ) u_dut_a (
    .mac_tx_clk  (clk),
    .mac_tx_rst_n(rst_n),
    .s_data      (a_data),
    .s_valid     (a_valid),
    .s_sof       (a_sof),
    .s_eof       (a_eof),
    .s_ready     (a_ready),
    .tx_data     (a_tx_data),
    .tx_dv       (a_tx_dv),
    .tx_er       (a_tx_er),
    .tx_underrun (a_tx_ur),
    .frame_cnt   (a_fcnt)
  );

  mac_tx_framer #(
    .PREAMBLE_LEN (7),
    .IFG_LEN      (12),
    .MIN_FRAME_LEN(0),
    .FCS_EN       (1'b1)
  ) u_dut_b (
    .mac_tx_clk  (clk),
    .mac_tx_rst_n(rst_n),
    .s_data      (b_data),
    .s_valid     (b_valid),
    .s_sof       (b_sof),
    .s_eof       (b_eof),
    .s_ready     (b_ready),
    .tx_data     (b_tx_data),
    .tx_dv       (b_tx_dv),
    .tx_er       (b_tx_er),
    .tx_underrun (b_tx_ur),
    .frame_cnt   (b_fcnt)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   runs[$];
  logic [7:0] pay [64];
  bit   mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic void push(input bit sel, input logic [7:0] d, input logic er,
                               input logic ur);
    exp_t e;
    e.d  = d;
    e.er = er;
    e.ur = ur;
    if (sel) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endfunction

  function automatic void push_hdr(input bit sel);
    for (int k = 0; k < 7; k++) push(sel, 8'h55, 1'b0, 1'b0);
    push(sel, 8'hD5, 1'b0, 1'b0);
  endfunction

  // Full expected frame with padding to min_len and FCS from the reference model.
  function automatic void expect_frame(input bit sel, input int n, input int min_len);
    logic [31:0] crc;
    crc = 32'hFFFF_FFFF;
    push_hdr(sel);
    for (int i = 0; i < n; i++) begin
      push(sel, pay[i], 1'b0, 1'b0);
      crc = crc_upd(crc, pay[i]);
    end
    for (int i = n; i < min_len; i++) begin
      push(sel, 8'h00, 1'b0, 1'b0);
      crc = crc_upd(crc, 8'h00);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) push(sel, crc[8*k +: 8], 1'b0, 1'b0);
  endfunction

  function automatic int last_run(input int k);
    if (runs.size() > k) return runs[runs.size() - 1 - k];
    return -1;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic sof, input logic eof,
                       input logic [7:0] d);
    if (sel) begin
      b_valid = v; b_sof = sof; b_eof = eof; b_data = d;
    end else begin
      a_valid = v; a_sof = sof; a_eof = eof; a_data = d;
    end
  endtask

  // Sends pay[0..n-1]. drop_after: byte index before which s_valid drops for one cycle.
  // rst_at: byte index at which reset pulses for one cycle and the frame is abandoned.
  task automatic send_frame(input bit sel, input int n, input int drop_after,
                            input int rst_at);
    for (int i = 0; i < n; i++) begin
      int t;
      bit acc;
      if (i == rst_at) begin
        drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (i == drop_after) begin
        drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
      end
      drive(sel, 1'b1, i == 0, i == n - 1, pay[i]);
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 500) begin
        @(negedge clk);
        acc = sel ? b_ready : a_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        chk("handshake_timeout", 32'(acc), 32'd1);
        drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        return;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || a_tx_dv || b_tx_dv) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait_timeout", 32'(t < 2000), 32'd1);
    @(negedge clk);
  endtask

  // Monitor / scoreboard.
  int a_hi = 0;
  int a_lo = 0;
  bit a_prev = 1'b0;
  bit a_seen = 1'b0;
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (a_tx_dv) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_dv actual=0x%0h required=no byte t=%0t", a_tx_data,
                   $time);
        end else begin
          e = exp_a.pop_front();
          chk("a_tx_data", 32'(a_tx_data), 32'(e.d));
          chk("a_er_underrun", 32'({a_tx_er, a_tx_ur}), 32'({e.er, e.ur}));
        end
        if (!a_prev) begin
          if (a_seen) runs.push_back(a_lo);
          a_hi = 0;
        end
        a_hi++;
        a_seen = 1'b1;
      end else begin
        chk("a_idle_outputs", 32'({a_tx_er, a_tx_ur, a_tx_data}), 32'd0);
        if (a_prev) begin
          runs.push_back(a_hi);
          a_lo = 0;
        end
        a_lo++;
      end
      a_prev = a_tx_dv;

      if (b_tx_dv) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_dv actual=0x%0h required=no byte t=%0t", b_tx_data,
                   $time);
        end else begin
          e = exp_b.pop_front();
          chk("b_tx_data", 32'(b_tx_data), 32'(e.d));
          chk("b_er_underrun", 32'({b_tx_er, b_tx_ur}), 32'({e.er, e.ur}));
        end
      end else begin
        chk("b_idle_outputs", 32'({b_tx_er, b_tx_ur, b_tx_data}), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);  // s_ready must stay low in reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_dv", 32'(a_tx_dv), 32'd0);
    chk("rst_tx_data", 32'(a_tx_data), 32'd0);
    chk("rst_tx_er_ur", 32'({a_tx_er, a_tx_ur}), 32'd0);
    chk("rst_frame_cnt", 32'(a_fcnt), 32'd0);
    chk("rst_s_ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    mon_en = 1'b1;

    // Non-sof byte in IDLE is flushed without transmitting.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
    @(negedge clk);
    chk("idle_discard_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("idle_discard_no_dv", 32'(a_tx_dv), 32'd0);

    // 64-byte frame 0x00..0x3F.
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    expect_frame(1'b0, 64, 60);
    send_frame(1'b0, 64, -1, -1);
    wait_idle();
    chk("f64_frame_cnt", 32'(a_fcnt), 32'd1);
    chk("f64_dv_len", 32'(last_run(0)), 32'd76);

    // 10-byte frame, padded to 60.
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'hC0 + i);
    expect_frame(1'b0, 10, 60);
    send_frame(1'b0, 10, -1, -1);
    wait_idle();
    chk("pad_frame_cnt", 32'(a_fcnt), 32'd2);
    chk("pad_dv_len", 32'(last_run(0)), 32'd72);

    // Back-to-back 64-byte frames with sof held valid.
    for (int i = 0; i < 64; i++) pay[i] = 8'(8'hFF - i);
    expect_frame(1'b0, 64, 60);
    expect_frame(1'b0, 64, 60);
    send_frame(1'b0, 64, -1, -1);
    send_frame(1'b0, 64, -1, -1);
    wait_idle();
    chk("b2b_frame_cnt", 32'(a_fcnt), 32'd4);
    chk("b2b_first_len", 32'(last_run(2)), 32'd76);
    chk("b2b_ifg", 32'(last_run(1)), 32'd12);
    chk("b2b_second_len", 32'(last_run(0)), 32'd76);

    // Underrun after byte 20, then a clean frame.
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3 + 1);
    push_hdr(1'b0);
    for (int i = 0; i < 20; i++) push(1'b0, pay[i], 1'b0, 1'b0);
    push(1'b0, 8'h00, 1'b1, 1'b1);
    send_frame(1'b0, 64, 20, -1);
    wait_idle();
    chk("ur_frame_cnt", 32'(a_fcnt), 32'd4);
    chk("ur_dv_len", 32'(last_run(0)), 32'd29);
    expect_frame(1'b0, 64, 60);
    send_frame(1'b0, 64, -1, -1);
    wait_idle();
    chk("ur_next_frame_cnt", 32'(a_fcnt), 32'd5);
    chk("ur_next_dv_len", 32'(last_run(0)), 32'd76);
    chk("ur_gap_min", 32'(last_run(1) >= 12), 32'd1);

    // Reset pulse at payload byte 30.
    for (int i = 0; i < 64; i++) pay[i] = 8'(8'h40 + i);
    push_hdr(1'b0);
    for (int i = 0; i < 30; i++) push(1'b0, pay[i], 1'b0, 1'b0);
    send_frame(1'b0, 64, -1, 30);
    @(negedge clk);
    chk("mid_rst_tx_dv", 32'(a_tx_dv), 32'd0);
    chk("mid_rst_outputs", 32'({a_tx_er, a_tx_ur, a_tx_data}), 32'd0);
    chk("mid_rst_frame_cnt", 32'(a_fcnt), 32'd0);
    chk("mid_rst_s_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_truncated", 32'(exp_a.size()), 32'd0);
    @(posedge clk);
    #1;
    expect_frame(1'b0, 64, 60);
    fork
      begin
        @(negedge clk);
        chk("sof_same_cycle_dv", 32'(a_tx_dv), 32'd0);
        @(negedge clk);
        chk("sof_next_cycle_dv", 32'({a_tx_dv, a_tx_data}), 32'h155);
      end
    join_none
    send_frame(1'b0, 64, -1, -1);
    wait_idle();
    chk("post_rst_frame_cnt", 32'(a_fcnt), 32'd1);

    // "123456789" with padding disabled: FCS 26 39 F4 CB.
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    push_hdr(1'b1);
    for (int i = 0; i < 9; i++) push(1'b1, pay[i], 1'b0, 1'b0);
    push(1'b1, 8'h26, 1'b0, 1'b0);
    push(1'b1, 8'h39, 1'b0, 1'b0);
    push(1'b1, 8'hF4, 1'b0, 1'b0);
    push(1'b1, 8'hCB, 1'b0, 1'b0);
    send_frame(1'b1, 9, -1, -1);
    wait_idle();
    chk("b_frame_cnt", 32'(b_fcnt), 32'd1);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
